lobster_ptw: RTL and testbench

Hardware page-table walker directly upstream of `lobster_mmu`. On a TLB miss it walks the two-level in-memory page table rooted at `ptbr` over a simple memory read port. It then emits one 64-bit TLB entry on `tlb_entry`/`tlb_we`, which wire straight to the MMU's `page_in`/`we`, or it reports a translation fault. One walk is in flight at a time, and misses are back-pressured through `miss_ready`.

---
 rtl/lobster_mmu_pkg.sv | 46 ++++
 rtl/lobster_ptw.sv | 144 ++++++++++++++
 tb/tb_lobster_ptw.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lobster_mmu_pkg.sv
// Shared definitions for the lobster MMU and its page-table walker.
// Covers PTE/TLB-entry field positions, address-width helpers and the walker state type.
package lobster_mmu_pkg;

  localparam int unsigned PAGE_SHIFT     = 12;
  localparam int unsigned VPN0_BITS      = 12;
  localparam int unsigned TABLE_SHIFT    = 15;
  localparam int unsigned PTE_SHIFT      = 3;
  localparam int unsigned PTE_BITS       = 64;
  localparam int unsigned TLB_ENTRY_BITS = 64;

  // PTE bit positions
  localparam int unsigned PTE_V          = 0;
  localparam int unsigned PTE_R          = 1;
  localparam int unsigned PTE_W          = 2;
  localparam int unsigned PTE_X          = 3;
  localparam int unsigned PTE_L          = 4;
  localparam int unsigned PTE_SW_LSB     = 5;
  localparam int unsigned PTE_FLAGS_BITS = 12;
  localparam int unsigned PTE_PPN_LSB    = 12;

  // TLB entry field offsets; the VPN field sits directly above the PPN
  localparam int unsigned TLB_FLAGS_LSB  = 0;
  localparam int unsigned TLB_PPN_LSB    = 12;

  function automatic int unsigned vpn_bits(input int unsigned aw);
    return aw - PAGE_SHIFT;
  endfunction

  function automatic int unsigned ppn_bits(input int unsigned aw);
    return aw - PAGE_SHIFT;
  endfunction

  function automatic int unsigned tlb_vpn_lsb(input int unsigned aw);
    return TLB_PPN_LSB + ppn_bits(aw);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    L1,
    L2,
    WRITE,
    FAULT
  } ptw_state_t;

endpackage

// File: rtl/lobster_ptw.sv
// Two-level hardware page-table walker feeding lobster_mmu.
// Walks one TLB miss at a time and emits either a TLB entry write or a fault pulse.
module lobster_ptw
  import lobster_mmu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] miss_vaddr,
  input  logic [ADDR_WIDTH-1:0] ptbr,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [PTE_BITS-1:0]   mem_rdata,
  input  logic                  mem_err,
  output logic                  tlb_we,
  output logic [TLB_ENTRY_BITS-1:0] tlb_entry,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_vaddr
);

  localparam int unsigned VPN_W   = vpn_bits(ADDR_WIDTH);
  localparam int unsigned PPN_W   = ppn_bits(ADDR_WIDTH);
  localparam int unsigned BASE_W  = ADDR_WIDTH - TABLE_SHIFT;
  localparam int unsigned VPN_LSB = tlb_vpn_lsb(ADDR_WIDTH);

  ptw_state_t               state;
  logic [VPN_W-1:0]         vpn;
  logic [BASE_W-1:0]        l2_base;

  logic [PPN_W-1:0]         pte_ppn;
  logic                     pte_v;
  logic                     pte_leaf;
  logic [PTE_FLAGS_BITS-1:0] leaf_flags;
  logic [PPN_W-1:0]         super_ppn;
  logic                     unused_bits;

  assign pte_ppn   = mem_rdata[PTE_PPN_LSB +: PPN_W];
  assign pte_v     = mem_rdata[PTE_V];
  assign pte_leaf  = mem_rdata[PTE_L];
  assign super_ppn = {pte_ppn[PPN_W-1:VPN0_BITS], vpn[VPN0_BITS-1:0]};
  assign unused_bits = ^{mem_rdata[PTE_BITS-1:PTE_PPN_LSB+PPN_W],
                         miss_vaddr[PAGE_SHIFT-1:0], ptbr[TABLE_SHIFT-1:0]};

  // Every installed entry is a leaf, so L is always set in the written flags
  always_comb begin
    leaf_flags        = mem_rdata[PTE_FLAGS_BITS-1:0];
    leaf_flags[PTE_L] = 1'b1;
  end

  function automatic logic [TLB_ENTRY_BITS-1:0] pack_entry(
    input logic [VPN_W-1:0]          v,
    input logic [PPN_W-1:0]          p,
    input logic [PTE_FLAGS_BITS-1:0] f
  );
    logic [TLB_ENTRY_BITS-1:0] e;
    e = '0;
    e[VPN_LSB +: VPN_W]                = v;
    e[TLB_PPN_LSB +: PPN_W]            = p;
    e[TLB_FLAGS_LSB +: PTE_FLAGS_BITS] = f;
    return e;
  endfunction

  // ptbr feeds the L1 address combinationally; the L2 base is captured from the L1 PTE
  always_comb begin
    mem_addr = '0;
    case (state)
      L1:      mem_addr = {ptbr[ADDR_WIDTH-1:TABLE_SHIFT], vpn[VPN_W-1:VPN0_BITS], 3'b000};
      L2:      mem_addr = {l2_base, vpn[VPN0_BITS-1:0], 3'b000};
      default: mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      miss_ready  <= 1'b1;
      mem_req     <= 1'b0;
      tlb_we      <= 1'b0;
      fault       <= 1'b0;
      vpn         <= '0;
      l2_base     <= '0;
      tlb_entry   <= '0;
      fault_vaddr <= '0;
    end else begin
      tlb_we <= 1'b0;
      fault  <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_valid) begin
            fault_vaddr <= miss_vaddr;
            vpn         <= miss_vaddr[ADDR_WIDTH-1:PAGE_SHIFT];
            miss_ready  <= 1'b0;
            mem_req     <= 1'b1;
            state       <= L1;
          end
        end
        L1: begin
          if (mem_ack) begin
            if (mem_err || !pte_v) begin
              mem_req <= 1'b0;
              fault   <= 1'b1;
              state   <= FAULT;
            end else if (pte_leaf) begin
              mem_req   <= 1'b0;
              tlb_we    <= 1'b1;
              tlb_entry <= pack_entry(vpn, super_ppn, leaf_flags);
              state     <= WRITE;
            end else begin
              l2_base <= pte_ppn[PPN_W-1:PTE_SHIFT];
              state   <= L2;
            end
          end
        end
        L2: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_err || !pte_v) begin
              fault <= 1'b1;
              state <= FAULT;
            end else begin
              tlb_we    <= 1'b1;
              tlb_entry <= pack_entry(vpn, pte_ppn, leaf_flags);
              state     <= WRITE;
            end
          end
        end
        WRITE, FAULT: begin
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          mem_req    <= 1'b0;
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lobster_ptw.sv
// Self-checking bench for lobster_ptw: a memory responder serves PTEs from a sparse
// table and an address-arithmetic reference model predicts every walk's outcome.
module tb_lobster_ptw;

  localparam int unsigned AW = 36;

  logic          clk;
  logic          rst;
  logic          miss_valid;
  logic          miss_ready;
  logic [AW-1:0] miss_vaddr;
  logic [AW-1:0] ptbr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [63:0]   mem_rdata;
  logic          mem_err;
  logic          tlb_we;
  logic [63:0]   tlb_entry;
  logic          fault;
  logic [AW-1:0] fault_vaddr;

  lobster_ptw #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_vaddr(miss_vaddr),
    .ptbr(ptbr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .tlb_we(tlb_we), .tlb_entry(tlb_entry),
    .fault(fault), .fault_vaddr(fault_vaddr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [63:0]   mem    [bit [35:0]];
  bit            errmap [bit [35:0]];
  int unsigned   d1 = 0;
  int unsigned   d2 = 0;
  bit            resp_en = 1'b1;
  bit [35:0]     reads[$];
  bit            addr_unstable = 1'b0;

  // walk observations
  int            res_n_we, res_n_fault, res_evt, res_done;
  logic [63:0]   res_entry;
  logic [AW-1:0] res_fvaddr;

  // model predictions
  bit            exp_fault;
  logic [63:0]   exp_entry;
  int            exp_evt, exp_done, exp_nreads;
  bit [35:0]     exp_a1, exp_a2;

  function automatic logic [63:0] mem_val(input bit [35:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // Memory slave: acks each request after d1 (first read) or d2 (second read) wait cycles
  initial begin : responder
    bit          in_req;
    bit [35:0]   req_addr;
    int unsigned waitc;
    int unsigned lvl;
    in_req = 1'b0; req_addr = '0; waitc = 0; lvl = 0;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        mem_ack = 1'b0;
        mem_err = 1'b0;
        if (rst || !mem_req) begin
          in_req = 1'b0;
          lvl    = 0;
        end else begin
          if (!in_req) begin
            in_req   = 1'b1;
            req_addr = mem_addr;
            waitc    = 0;
            lvl++;
            reads.push_back(mem_addr);
          end else if (mem_addr !== req_addr) begin
            addr_unstable = 1'b1;
          end
          if (waitc >= ((lvl == 1) ? d1 : d2)) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_val(req_addr);
            mem_err   = errmap.exists(req_addr);
            in_req    = 1'b0;
          end else begin
            waitc++;
          end
        end
      end
    end
  end

  // Reference model: plain address arithmetic over the sparse memory image
  task automatic predict(input logic [AW-1:0] va, input logic [AW-1:0] root);
    longint unsigned vpn, vpn1, vpn0, a1, a2, pte, ppn;
    vpn  = longint'(va) >> 12;
    vpn1 = vpn >> 12;
    vpn0 = vpn % 4096;
    a1   = (longint'(root) / 32768) * 32768 + vpn1 * 8;
    exp_a1 = a1[35:0]; exp_a2 = '0; exp_nreads = 1; exp_entry = '0;
    pte = mem_val(a1[35:0]);
    if (errmap.exists(a1[35:0]) || (pte % 2) == 0) begin
      exp_fault = 1'b1;
      exp_evt   = 2 + int'(d1);
    end else begin
      ppn = (pte >> 12) % (64'd1 << 24);
      if (((pte >> 4) % 2) == 1) begin
        exp_fault = 1'b0;
        exp_entry = (vpn << 36) + ((((ppn >> 12) * 4096) + vpn0) << 12) + ((pte % 4096) | 16);
        exp_evt   = 2 + int'(d1);
      end else begin
        a2 = (ppn >> 3) * 32768 + vpn0 * 8;
        exp_a2 = a2[35:0]; exp_nreads = 2;
        pte = mem_val(a2[35:0]);
        exp_evt = 3 + int'(d1) + int'(d2);
        if (errmap.exists(a2[35:0]) || (pte % 2) == 0) begin
          exp_fault = 1'b1;
        end else begin
          exp_fault = 1'b0;
          exp_entry = (vpn << 36) + (((pte >> 12) % (64'd1 << 24)) << 12) + ((pte % 4096) | 16);
        end
      end
    end
    exp_done = exp_evt + 1;
  endtask

  // One miss presented in cycle 0; observes until miss_ready returns (bounded)
  task automatic run_walk(input logic [AW-1:0] va, input logic [AW-1:0] root);
    int cyc;
    res_n_we = 0; res_n_fault = 0; res_evt = -1; res_entry = '0;
    @(negedge clk);
    reads.delete();
    addr_unstable = 1'b0;
    miss_vaddr = va; ptbr = root; miss_valid = 1'b1;
    @(negedge clk);
    miss_valid = 1'b0;
    cyc = 1;
    while (!miss_ready && cyc < 200) begin
      if (tlb_we) begin res_n_we++; res_evt = cyc; res_entry = tlb_entry; end
      if (fault)  begin res_n_fault++; res_evt = cyc; end
      @(negedge clk);
      cyc++;
    end
    res_done   = cyc;
    res_fvaddr = fault_vaddr;
  endtask

  task automatic clear_mem();
    mem.delete();
    errmap.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; miss_valid = 1'b0; miss_vaddr = '0; ptbr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({miss_ready, mem_req, tlb_we, fault} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got ready/req/we/fault=%b want 1000", {miss_ready, mem_req, tlb_we, fault});
    end
    checks++;
    if ({mem_addr, tlb_entry, fault_vaddr} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h entry=%h fva=%h want all 0", mem_addr, tlb_entry, fault_vaddr);
    end
  endtask

  task automatic test_two_level();
    clear_mem();
    d1 = 0; d2 = 0;
    mem[36'h0_0010_0918] = 64'h0000_0000_0200_0001;
    mem[36'h0_0200_22B0] = 64'h0000_0000_0ABC_D00F;
    run_walk(36'h1_2345_6789, 36'h0_0010_0000);
    checks++;
    if (res_n_we !== 1 || res_n_fault !== 0 || res_evt !== 3 || res_done !== 4) begin
      errors++;
      $display("FAIL two_level_timing got we=%0d flt=%0d evt=%0d done=%0d want 1 0 3 4", res_n_we, res_n_fault, res_evt, res_done);
    end
    checks++;
    if (res_entry !== 64'h0123_4560_0ABC_D01F) begin
      errors++;
      $display("FAIL two_level_entry got %h want 0123456000abcd01f", res_entry);
    end
    checks++;
    if (reads.size() != 2 || reads[0] !== 36'h0_0010_0918 || reads[1] !== 36'h0_0200_22B0) begin
      errors++;
      $display("FAIL two_level_addrs got n=%0d a0=%h a1=%h want 2 000100918 0020022b0",
               reads.size(), (reads.size() > 0) ? reads[0] : 36'h0, (reads.size() > 1) ? reads[1] : 36'h0);
    end
  endtask

  task automatic test_superpage();
    clear_mem();
    d1 = 0; d2 = 0;
    mem[36'h0_0010_0918] = (64'h45_6000 << 12) | 64'h13;
    run_walk(36'h1_2345_6789, 36'h0_0010_0000);
    checks++;
    if (res_n_we !== 1 || res_evt !== 2 || res_done !== 3 || reads.size() != 1) begin
      errors++;
      $display("FAIL superpage_timing got we=%0d evt=%0d done=%0d reads=%0d want 1 2 3 1", res_n_we, res_evt, res_done, reads.size());
    end
    checks++;
    if (res_entry !== 64'h0123_4564_5645_6013) begin
      errors++;
      $display("FAIL superpage_entry got %h want 0123456456456013", res_entry);
    end
  endtask

  task automatic test_faults();
    logic [63:0] held;
    clear_mem();
    d1 = 0; d2 = 0;
    held = tlb_entry;
    mem[36'h0_0010_0918] = 64'h0000_0000_0200_0001;
    mem[36'h0_0200_22B0] = 64'h0000_0000_0ABC_D00E;
    run_walk(36'h1_2345_6789, 36'h0_0010_0000);
    checks++;
    if (res_n_fault !== 1 || res_n_we !== 0 || res_evt !== 3 || res_fvaddr !== 36'h1_2345_6789) begin
      errors++;
      $display("FAIL l2_invalid got flt=%0d we=%0d evt=%0d fva=%h want 1 0 3 123456789", res_n_fault, res_n_we, res_evt, res_fvaddr);
    end
    checks++;
    if (tlb_entry !== held) begin
      errors++;
      $display("FAIL entry_held got %h want %h", tlb_entry, held);
    end
    errmap[36'h0_0010_0918] = 1'b1;
    run_walk(36'h1_2345_6789, 36'h0_0010_0000);
    checks++;
    if (res_n_fault !== 1 || res_n_we !== 0 || res_evt !== 2 || res_done !== 3 || reads.size() != 1) begin
      errors++;
      $display("FAIL l1_bus_err got flt=%0d we=%0d evt=%0d done=%0d reads=%0d want 1 0 2 3 1",
               res_n_fault, res_n_we, res_evt, res_done, reads.size());
    end
  endtask

  task automatic test_back_pressure();
    clear_mem();
    d1 = 5; d2 = 5;
    mem[36'h0_0010_0918] = 64'h0000_0000_0200_0001;
    mem[36'h0_0200_22B0] = 64'h0000_0000_0ABC_D00F;
    run_walk(36'h1_2345_6789, 36'h0_0010_0000);
    checks++;
    if (res_n_we !== 1 || res_evt !== 13 || res_done !== 14 || addr_unstable) begin
      errors++;
      $display("FAIL back_pressure got we=%0d evt=%0d done=%0d unstable=%0b want 1 13 14 0", res_n_we, res_evt, res_done, addr_unstable);
    end
    checks++;
    if (res_entry !== 64'h0123_4560_0ABC_D01F) begin
      errors++;
      $display("FAIL back_pressure_entry got %h want 0123456000abcd01f", res_entry);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] va_a, va_b;
    int            cyc, done_a, nreads_a;
    bit            early;
    clear_mem();
    d1 = 2; d2 = 2;
    va_a = 36'h1_2345_6789;
    va_b = 36'h0_ABCD_E123;
    ptbr = 36'h0_0010_0000;
    mem[36'h0_0010_0918] = 64'h0000_0000_0200_0001;
    mem[36'h0_0200_22B0] = 64'h0000_0000_0ABC_D00F;
    mem[36'h0_0010_0558] = (64'h77_7000 << 12) | 64'h1F;
    predict(va_a, ptbr);
    done_a = exp_done; nreads_a = exp_nreads;
    @(negedge clk);
    reads.delete();
    miss_vaddr = va_a; miss_valid = 1'b1;
    @(negedge clk);
    miss_vaddr = va_b;
    cyc = 1; early = 1'b0;
    while (!miss_ready && cyc < 200) begin
      if (fault_vaddr !== va_a) early = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (early || cyc !== done_a || reads.size() != nreads_a) begin
      errors++;
      $display("FAIL busy_not_taken got early=%0b done=%0d reads=%0d want 0 %0d %0d", early, cyc, reads.size(), done_a, nreads_a);
    end
    predict(va_b, ptbr);
    reads.delete();
    @(negedge clk);
    miss_valid = 1'b0;
    checks++;
    if (fault_vaddr !== va_b || miss_ready !== 1'b0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL held_miss_taken got fva=%h ready=%b req=%b want %h 0 1", fault_vaddr, miss_ready, mem_req, va_b);
    end
    res_entry = '0; cyc = 0;
    while (!miss_ready && cyc < 200) begin
      if (tlb_we) res_entry = tlb_entry;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (res_entry !== exp_entry || reads.size() != exp_nreads) begin
      errors++;
      $display("FAIL held_miss_walk got entry=%h reads=%0d want %h %0d", res_entry, reads.size(), exp_entry, exp_nreads);
    end
  endtask

  task automatic test_reset_mid_walk();
    int n_out;
    clear_mem();
    d1 = 0; d2 = 20;
    mem[36'h0_0010_0918] = 64'h0000_0000_0200_0001;
    mem[36'h0_0200_22B0] = 64'h0000_0000_0ABC_D00F;
    @(negedge clk);
    reads.delete();
    miss_vaddr = 36'h1_2345_6789; ptbr = 36'h0_0010_0000; miss_valid = 1'b1;
    @(negedge clk);
    miss_valid = 1'b0;
    for (int i = 0; i < 10 && reads.size() < 2; i++) @(negedge clk);
    checks++;
    if (reads.size() != 2 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL reach_l2 got reads=%0d req=%b want 2 1", reads.size(), mem_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || miss_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got req=%b ready=%b want 0 1", mem_req, miss_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    resp_en = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_err = 1'b0; mem_rdata = 64'h0000_0000_0ABC_D01F;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_out = 0;
    repeat (3) begin
      @(negedge clk);
      if (tlb_we || fault || mem_req || !miss_ready) n_out++;
    end
    checks++;
    if (n_out != 0) begin
      errors++;
      $display("FAIL stray_ack got %0d active cycles want 0", n_out);
    end
    resp_en = 1'b1;
    d2 = 0;
    predict(36'h1_2345_6789, 36'h0_0010_0000);
    run_walk(36'h1_2345_6789, 36'h0_0010_0000);
    checks++;
    if (res_n_we !== 1 || res_evt !== exp_evt || res_entry !== exp_entry) begin
      errors++;
      $display("FAIL walk_after_reset got we=%0d evt=%0d entry=%h want 1 %0d %h", res_n_we, res_evt, res_entry, exp_evt, exp_entry);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0]   va, root;
    longint unsigned vpn, a1, a2;
    logic [23:0]     ppn1;
    logic [63:0]     pte1, pte2;
    int unsigned     kind;
    for (int unsigned it = 0; it < 40; it++) begin
      clear_mem();
      d1   = $urandom_range(0, 3);
      d2   = $urandom_range(0, 3);
      va   = {4'($urandom_range(15, 0)), 32'($urandom)};
      root = {4'($urandom_range(15, 0)), 32'($urandom)};
      vpn  = longint'(va) >> 12;
      a1   = (longint'(root) / 32768) * 32768 + (vpn >> 12) * 8;
      kind = $urandom_range(0, 9);
      ppn1 = 24'($urandom);
      pte1 = {28'($urandom), ppn1, 7'($urandom), (kind == 2 || kind == 3), 3'($urandom), (kind != 1)};
      mem[a1[35:0]] = pte1;
      if (kind == 0) errmap[a1[35:0]] = 1'b1;
      if (kind >= 4) begin
        a2   = (longint'(ppn1) / 8) * 32768 + (vpn % 4096) * 8;
        pte2 = {28'($urandom), 24'($urandom), 7'($urandom), 1'($urandom), 3'($urandom),
                ($urandom_range(0, 9) != 0)};
        mem[a2[35:0]] = pte2;
        if ($urandom_range(0, 9) == 0) errmap[a2[35:0]] = 1'b1;
      end
      predict(va, root);
      run_walk(va, root);
      checks++;
      if (res_n_we !== (exp_fault ? 0 : 1) || res_n_fault !== (exp_fault ? 1 : 0) ||
          res_evt !== exp_evt || res_done !== exp_done) begin
        errors++;
        $display("FAIL rand%0d_timing got we=%0d flt=%0d evt=%0d done=%0d want fault=%0b evt=%0d done=%0d",
                 it, res_n_we, res_n_fault, res_evt, res_done, exp_fault, exp_evt, exp_done);
      end
      checks++;
      if (reads.size() != exp_nreads || reads[0] !== exp_a1 ||
          (exp_nreads == 2 && reads[reads.size()-1] !== exp_a2) || res_fvaddr !== va) begin
        errors++;
        $display("FAIL rand%0d_addrs got n=%0d a1=%h fva=%h want %0d %h %h %h",
                 it, reads.size(), (reads.size() > 0) ? reads[0] : 36'h0, res_fvaddr, exp_nreads, exp_a1, exp_a2, va);
      end
      if (!exp_fault) begin
        checks++;
        if (res_entry !== exp_entry) begin
          errors++;
          $display("FAIL rand%0d_entry got %h want %h", it, res_entry, exp_entry);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_level();
    test_superpage();
    test_faults();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_walk();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
